// File: rtl/bfp_expand_if.sv
// Sample-stream bundle for the block-floating-point expander: mantissa/exponent
// stream in, expanded I/Q samples plus packet status out.
interface bfp_expand_if #(
  parameter int IW = 40,
  parameter int MW = 16,
  parameter int LW = 12
);
  logic          i_sop;
  logic          i_eop;
  logic          i_vld;
  logic [4:0]    i_exp;
  logic [MW-1:0] i_man_re;
  logic [MW-1:0] i_man_im;

  logic          o_sop;
  logic          o_eop;
  logic          o_vld;
  logic [IW-1:0] o_dout_re;
  logic [IW-1:0] o_dout_im;
  logic          o_sat;
  logic [LW-1:0] o_len;
  logic          o_err;

  modport master (
    output i_sop, i_eop, i_vld, i_exp, i_man_re, i_man_im,
    input  o_sop, o_eop, o_vld, o_dout_re, o_dout_im, o_sat, o_len, o_err
  );

  modport slave (
    input  i_sop, i_eop, i_vld, i_exp, i_man_re, i_man_im,
    output o_sop, o_eop, o_vld, o_dout_re, o_dout_im, o_sat, o_len, o_err
  );
endinterface

// File: rtl/bfp_expand.sv
// Block-floating-point expander: packet framing FSM (stage 1) followed by a
// saturating per-component left shift (stage 2); fixed 2-cycle latency.
module bfp_expand #(
  parameter int IW = 40,
  parameter int MW = 16,
  parameter int LW = 12
) (
  input  logic          clk,
  input  logic          rst,
  bfp_expand_if.slave   bus
);

  // Wide enough to hold any mantissa shifted by 31 without losing the sign.
  localparam int WW = IW + 32;
  localparam logic [LW-1:0] LEN_MAX = '1;

  typedef enum logic {IDLE, PKT} state_t;

  state_t        r_state;
  logic [4:0]    r_exp;
  logic [LW-1:0] r_cnt;
  logic          r_err;

  logic          r_s1_vld;
  logic          r_s1_sop;
  logic          r_s1_eop;
  logic [4:0]    r_s1_exp;
  logic [MW-1:0] r_s1_re;
  logic [MW-1:0] r_s1_im;
  logic [LW-1:0] r_s1_len;

  logic          r_o_sop;
  logic          r_o_eop;
  logic          r_o_vld;
  logic [IW-1:0] r_o_re;
  logic [IW-1:0] r_o_im;
  logic          r_o_sat;
  logic [LW-1:0] r_o_len;

  logic [LW-1:0] w_cnt_inc;
  logic [IW:0]   w_re;
  logic [IW:0]   w_im;

  assign w_cnt_inc = (r_cnt == LEN_MAX) ? r_cnt : r_cnt + LW'(1);

  // Returns {saturated, value}; clamps toward the mantissa's sign on overflow.
  function automatic logic [IW:0] shift_sat(input logic [MW-1:0] m, input logic [4:0] e);
    logic [WW-1:0] w;
    w = {{(WW-MW){m[MW-1]}}, m} << e;
    if (w[WW-1:IW-1] == {(WW-IW+1){m[MW-1]}})
      return {1'b0, w[IW-1:0]};
    return {1'b1, m[MW-1], {(IW-1){~m[MW-1]}}};
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_exp    <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_s1_vld <= 1'b0;
      r_s1_sop <= 1'b0;
      r_s1_eop <= 1'b0;
      r_s1_exp <= '0;
      r_s1_re  <= '0;
      r_s1_im  <= '0;
      r_s1_len <= '0;
    end else begin
      r_err    <= 1'b0;
      r_s1_vld <= 1'b0;
      r_s1_sop <= 1'b0;
      r_s1_eop <= 1'b0;
      r_s1_len <= '0;
      if (bus.i_vld) begin
        r_s1_re <= bus.i_man_re;
        r_s1_im <= bus.i_man_im;
        if (bus.i_sop) begin
          // A new sop always restarts; inside a packet it also flags the abandon.
          r_err    <= (r_state == PKT);
          r_exp    <= bus.i_exp;
          r_cnt    <= LW'(1);
          r_state  <= bus.i_eop ? IDLE : PKT;
          r_s1_vld <= 1'b1;
          r_s1_sop <= 1'b1;
          r_s1_eop <= bus.i_eop;
          r_s1_exp <= bus.i_exp;
          r_s1_len <= bus.i_eop ? LW'(1) : '0;
        end else if (r_state == IDLE) begin
          r_err <= 1'b1;
        end else begin
          r_cnt    <= w_cnt_inc;
          r_s1_vld <= 1'b1;
          r_s1_eop <= bus.i_eop;
          r_s1_exp <= r_exp;
          r_s1_len <= bus.i_eop ? w_cnt_inc : '0;
          if (bus.i_eop)
            r_state <= IDLE;
        end
      end
    end
  end

  assign w_re = shift_sat(r_s1_re, r_s1_exp);
  assign w_im = shift_sat(r_s1_im, r_s1_exp);

  always_ff @(posedge clk) begin
    if (rst || !r_s1_vld) begin
      r_o_vld <= 1'b0;
      r_o_sop <= 1'b0;
      r_o_eop <= 1'b0;
      r_o_re  <= '0;
      r_o_im  <= '0;
      r_o_sat <= 1'b0;
      r_o_len <= '0;
    end else begin
      r_o_vld <= 1'b1;
      r_o_sop <= r_s1_sop;
      r_o_eop <= r_s1_eop;
      r_o_re  <= w_re[IW-1:0];
      r_o_im  <= w_im[IW-1:0];
      r_o_sat <= w_re[IW] | w_im[IW];
      r_o_len <= r_s1_len;
    end
  end

  assign bus.o_sop     = r_o_sop;
  assign bus.o_eop     = r_o_eop;
  assign bus.o_vld     = r_o_vld;
  assign bus.o_dout_re = r_o_re;
  assign bus.o_dout_im = r_o_im;
  assign bus.o_sat     = r_o_sat;
  assign bus.o_len     = r_o_len;
  assign bus.o_err     = r_err;

endmodule

// File: doc/bfp_expand.md
BFP_EXPAND -- requirements
Module: bfp_expand

Interface
REQ-001 SHALL have parameter IW, default 40: output sample width per I/Q component, two's complement.
REQ-002 SHALL have parameter MW, default 16: input mantissa width per I/Q component, two's complement; MW < IW.
REQ-003 SHALL have parameter LW, default 12: packet length counter width.
REQ-004 SHALL have port clk, input, 1: clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port i_sop, input, 1: first sample of packet, qualified by i_vld.
REQ-007 SHALL have port i_eop, input, 1: last sample of packet, qualified by i_vld.
REQ-008 SHALL have port i_vld, input, 1: input sample valid.
REQ-009 SHALL have port i_exp, input, 5: packet shift exponent (0..31), sampled only on i_vld&i_sop.
REQ-010 SHALL have port i_man_re, input, MW: real mantissa.
REQ-011 SHALL have port i_man_im, input, MW: imaginary mantissa.
REQ-012 SHALL have port o_sop, output, 1: first expanded sample.
REQ-013 SHALL have port o_eop, output, 1: last expanded sample.
REQ-014 SHALL have port o_vld, output, 1: output sample valid.
REQ-015 SHALL have port o_dout_re, output, IW: expanded real sample.
REQ-016 SHALL have port o_dout_im, output, IW: expanded imaginary sample.
REQ-017 SHALL have port o_sat, output, 1: either component of the current output sample saturated.
REQ-018 SHALL have port o_len, output, LW: sample count of the packet, valid with o_vld&o_eop.
REQ-019 SHALL have port o_err, output, 1: one-cycle framing-error pulse.

Function
REQ-020 SHALL run a two-state FSM: IDLE and PKT; no backpressure, so every accepted sample is emitted.
REQ-021 IDLE->PKT on i_vld&i_sop&!i_eop; latch i_exp; length counter = 1.
REQ-022 i_vld&i_sop&i_eop in IDLE SHALL form a one-sample packet: o_sop=o_eop=1 on the same output, o_len=1; FSM stays IDLE.
REQ-023 In PKT each i_vld sample SHALL use the latched exponent and increment the counter; i_vld low cycles are gaps, with no output and no count.
REQ-024 PKT->IDLE on i_vld&i_eop; o_eop=1 on that sample, with o_len = final count.
REQ-025 The length counter SHALL saturate at 2^LW-1, with no wrap.
REQ-026 i_vld without i_sop in IDLE SHALL be dropped (no o_vld) and pulse o_err.
REQ-027 i_vld&i_sop in PKT SHALL pulse o_err, abandon the old packet with no o_eop for it, and restart as in REQ-021/022 with the new i_exp.
REQ-028 Each component SHALL be sign-extended to IW and arithmetically shifted left by the exponent; the result SHALL be exact whenever it fits in IW signed bits.
REQ-029 If the exact shifted value exceeds the IW signed range, the component SHALL clamp to 2^(IW-1)-1 (positive) or -2^(IW-1) (negative) and o_sat SHALL assert.
REQ-030 Zero mantissas SHALL never saturate.
REQ-031 Latency SHALL be exactly 2 cycles from input sample to output sample for o_sop, o_eop, o_vld, o_dout_*, o_sat and o_len.
REQ-032 o_err SHALL be 1 cycle after the offending input.
REQ-033 When o_vld=0, o_dout_*, o_sat, o_sop, o_eop and o_len SHALL be 0.

Reset
REQ-034 rst SHALL force the FSM to IDLE, clear the counter and latched exponent, and flush the pipeline.
REQ-035 All outputs SHALL be 0 from the cycle after rst is sampled high.
REQ-036 A packet in flight during rst SHALL be discarded with no o_eop emitted.
REQ-037 The first i_vld after rst is released SHALL be handled as in IDLE.

Verification
REQ-038 Expansion test: sop, exp=24, re=0x7FFF, im=0x8000, plus eop -> 2 cycles later re=0x7F_FF00_0000, im=0x80_0000_0000, o_sat=0, o_sop=o_eop=1, o_len=1.
REQ-039 Saturation test: exp=25, re=0x7FFF, im=0x0000 -> re=0x7F_FFFF_FFFF, im=0, o_sat=1; exp=31, re=0xFFFF -> 0xFF_8000_0000, o_sat=0.
REQ-040 Packet with gaps: 8 samples, exp=3, i_vld toggling each cycle -> 8 outputs, each equal to mantissa*8, o_eop only on the 8th, o_len=8.
REQ-041 Framing test: i_vld without i_sop in IDLE -> no output, o_err pulse; sop while in PKT -> o_err, no o_eop for the old packet, new exponent applied.
REQ-042 Reset test: rst asserted at the 3rd sample of a 10-sample packet -> all outputs 0, no o_eop, next sop packet correct.
REQ-043 Length saturation test: 5000-sample packet with LW=12 -> o_len=4095 at eop.
